// File: rtl/cwc_trace_pkg.sv
// Shared types and helpers for the ChipWatcher trace capture buffer.
package cwc_trace_pkg;

    localparam int DEPTH_LOG2_DEFAULT = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2,
        ST_READ    = 2'd3
    } trace_state_t;

    // Oldest stored word: address 0 until the buffer has filled, after which
    // the ring has wrapped and the oldest word sits just past the last write.
    function automatic logic [31:0] calc_start_addr(
        input logic [31:0] count,
        input logic [31:0] last_addr,
        input int unsigned depth_log2
    );
        logic [31:0] depth;
        depth = 32'd1 << depth_log2;
        if (count < depth) begin
            calc_start_addr = 32'd0;
        end else begin
            calc_start_addr = (last_addr + 32'd1) & (depth - 32'd1);
        end
    endfunction

endpackage

// File: rtl/cwc_trace_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port
// (1-cycle read latency). No reset so it maps onto block RAM.
module cwc_trace_ram #(
    parameter int DATA_WIDTH = 50,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

    // Write port and registered read port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/cwc_trace_buf.sv
// Trace capture buffer: stores {non_bus_din, bus_din} samples during the
// capture window, then streams them out oldest-first.
//
// Handshake: a word transfers on every cycle where rd_valid & rd_ready are
// both high; while rd_valid is high and rd_ready is low, rd_data and rd_last
// hold their values and rd_valid stays high.
module cwc_trace_buf
    import cwc_trace_pkg::*;
#(
    parameter int NON_BUS_NODE_NUM = 2,
    parameter int BUS_NODE_NUM     = 48,
    parameter int DATA_WIDTH       = NON_BUS_NODE_NUM + BUS_NODE_NUM,
    parameter int ADDR_WIDTH       = 16,
    parameter int DEPTH_LOG2       = DEPTH_LOG2_DEFAULT
) (
    input  logic                        trig_clk,
    input  logic                        jrstn,
    input  logic                        wt_ce,
    input  logic                        wt_en,
    input  logic [ADDR_WIDTH-1:0]       wt_addr,
    input  logic [NON_BUS_NODE_NUM-1:0] non_bus_din,
    input  logic [BUS_NODE_NUM-1:0]     bus_din,
    input  logic                        rd_start,
    input  logic                        rd_abort,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic                        rd_last,
    output logic                        cap_done,
    output logic [DEPTH_LOG2:0]         cap_count,
    output logic                        overrun
);

    localparam int CW = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] DEPTH_WORDS = {1'b1, {DEPTH_LOG2{1'b0}}};

    trace_state_t state, state_nx;

    logic                  wr_ok, in_read;
    logic                  wr_fire, start_fire, pop, last_pop;
    logic [CW-1:0]         count_q;
    logic [DEPTH_LOG2-1:0] last_addr, rd_ptr, issue_addr, start_addr;
    logic [CW-1:0]         issue_left, issue_left_eff;
    logic                  room, issue_en, issue_last;
    logic                  pend, pend_last;
    logic [DATA_WIDTH-1:0] ram_q;
    logic [1:0]            fifo_cnt;
    logic [DATA_WIDTH-1:0] e0_data, e1_data;
    logic                  e0_last, e1_last;
    logic [31:0]           start_full;
    logic                  start_unused;

    assign wr_fire    = wt_ce & wt_en & wr_ok & ~rd_abort;
    assign start_fire = (state == ST_DONE) & rd_start & ~rd_abort;
    assign pop        = rd_valid & rd_ready;
    assign last_pop   = pop & rd_last;

    assign rd_valid  = (fifo_cnt != 2'd0);
    assign rd_last   = rd_valid & e0_last;
    assign rd_data   = e0_data;
    assign cap_count = count_q;

    // FSM state register.
    always_ff @(posedge trig_clk or negedge jrstn) begin
        if (!jrstn) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // FSM next-state; abort overrides every other event.
    always_comb begin
        state_nx = state;
        if (rd_abort) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (wt_ce) state_nx = ST_CAPTURE;
                ST_CAPTURE: if (!wt_ce) state_nx = (count_q != '0) ? ST_DONE : ST_IDLE;
                ST_DONE:    if (rd_start) state_nx = ST_READ;
                ST_READ:    if (last_pop) state_nx = ST_IDLE;
                default:    state_nx = ST_IDLE;
            endcase
        end
    end

    // FSM output decode.
    always_comb begin
        wr_ok    = 1'b0;
        in_read  = 1'b0;
        cap_done = 1'b0;
        case (state)
            ST_IDLE, ST_CAPTURE: wr_ok = 1'b1;
            ST_DONE:             cap_done = 1'b1;
            ST_READ:             begin cap_done = 1'b1; in_read = 1'b1; end
            default:             ;
        endcase
    end

    // Capture bookkeeping: stored-word count, last write address, overrun.
    always_ff @(posedge trig_clk or negedge jrstn) begin
        if (!jrstn) begin
            count_q   <= '0;
            last_addr <= '0;
            overrun   <= 1'b0;
        end else if (rd_abort) begin
            count_q <= '0;
            overrun <= 1'b0;
        end else begin
            if (last_pop) begin
                count_q <= '0;
            end else if (wr_fire && count_q != DEPTH_WORDS) begin
                count_q <= count_q + CW'(1);
            end
            if (wr_fire) last_addr <= wt_addr[DEPTH_LOG2-1:0];
            if (wt_ce && wt_en && !wr_ok) overrun <= 1'b1;
        end
    end

    // The first RAM read is issued in the rd_start cycle itself so the first
    // word is valid two cycles later. Further reads are issued only when the
    // skid buffer is guaranteed a free slot for the returning data.
    always_comb begin
        start_full     = calc_start_addr(32'(count_q), 32'(last_addr), DEPTH_LOG2);
        start_addr     = start_full[DEPTH_LOG2-1:0];
        issue_addr     = start_fire ? start_addr : rd_ptr;
        issue_left_eff = start_fire ? count_q : issue_left;
        room           = ({1'b0, fifo_cnt} + {2'b00, pend}) <= ({2'b00, pop} + 3'd1);
        issue_en       = ~rd_abort & (start_fire | (in_read & (issue_left != '0) & room));
        issue_last     = (issue_left_eff == CW'(1));
    end

    assign start_unused = ^start_full[31:DEPTH_LOG2];

    // Read issue pointer, words remaining, and in-flight read tracking.
    always_ff @(posedge trig_clk or negedge jrstn) begin
        if (!jrstn) begin
            rd_ptr     <= '0;
            issue_left <= '0;
            pend       <= 1'b0;
            pend_last  <= 1'b0;
        end else if (rd_abort) begin
            issue_left <= '0;
            pend       <= 1'b0;
        end else begin
            pend      <= issue_en;
            pend_last <= issue_last;
            if (issue_en) begin
                rd_ptr     <= issue_addr + DEPTH_LOG2'(1);
                issue_left <= issue_left_eff - CW'(1);
            end
        end
    end

    // Two-entry skid buffer; e0 is the head presented on rd_data/rd_last.
    always_ff @(posedge trig_clk or negedge jrstn) begin
        if (!jrstn) begin
            fifo_cnt <= 2'd0;
            e0_data  <= '0;
            e1_data  <= '0;
            e0_last  <= 1'b0;
            e1_last  <= 1'b0;
        end else if (rd_abort) begin
            fifo_cnt <= 2'd0;
        end else begin
            case ({pend, pop})
                2'b10: begin
                    if (fifo_cnt == 2'd0) begin
                        e0_data <= ram_q;
                        e0_last <= pend_last;
                    end else begin
                        e1_data <= ram_q;
                        e1_last <= pend_last;
                    end
                    fifo_cnt <= fifo_cnt + 2'd1;
                end
                2'b01: begin
                    e0_data  <= e1_data;
                    e0_last  <= e1_last;
                    fifo_cnt <= fifo_cnt - 2'd1;
                end
                2'b11: begin
                    if (fifo_cnt == 2'd1) begin
                        e0_data <= ram_q;
                        e0_last <= pend_last;
                    end else begin
                        e0_data <= e1_data;
                        e0_last <= e1_last;
                        e1_data <= ram_q;
                        e1_last <= pend_last;
                    end
                end
                default: ;
            endcase
        end
    end

    generate
        if (ADDR_WIDTH > DEPTH_LOG2) begin : g_addr_unused
            logic addr_hi_unused;
            assign addr_hi_unused = ^wt_addr[ADDR_WIDTH-1:DEPTH_LOG2];
        end
    endgenerate

    cwc_trace_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk     (trig_clk),
        .wr_en   (wr_fire),
        .wr_addr (wt_addr[DEPTH_LOG2-1:0]),
        .wr_data ({non_bus_din, bus_din}),
        .rd_en   (issue_en),
        .rd_addr (issue_addr),
        .rd_data (ram_q)
    );

endmodule

// File: tb/tb_cwc_trace_buf.sv
// Directed bench for cwc_trace_buf (16-word RAM so the wrap case is short).
module tb_cwc_trace_buf;

  localparam int NB = 2;
  localparam int BB = 48;
  localparam int DW = NB + BB;
  localparam int AW = 16;
  localparam int DL = 4;

  logic          trig_clk = 1'b0;
  logic          jrstn;
  logic          wt_ce, wt_en;
  logic [AW-1:0] wt_addr;
  logic [NB-1:0] non_bus_din;
  logic [BB-1:0] bus_din;
  logic          rd_start, rd_abort, rd_ready;
  logic          rd_valid, rd_last, cap_done, overrun;
  logic [DW-1:0] rd_data;
  logic [DL:0]   cap_count;

  int total = 0;
  int bad = 0;
  logic [DW-1:0] exp_q[$];

  cwc_trace_buf #(
    .NON_BUS_NODE_NUM (NB),
    .BUS_NODE_NUM     (BB),
    .ADDR_WIDTH       (AW),
    .DEPTH_LOG2       (DL)
  ) dut (
    .trig_clk    (trig_clk),
    .jrstn       (jrstn),
    .wt_ce       (wt_ce),
    .wt_en       (wt_en),
    .wt_addr     (wt_addr),
    .non_bus_din (non_bus_din),
    .bus_din     (bus_din),
    .rd_start    (rd_start),
    .rd_abort    (rd_abort),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .rd_last     (rd_last),
    .cap_done    (cap_done),
    .cap_count   (cap_count),
    .overrun     (overrun)
  );

  // clock
  always #5 trig_clk = ~trig_clk;

  // watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: got=no_finish exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    wt_ce = 1'b0; wt_en = 1'b0; wt_addr = '0;
    non_bus_din = '0; bus_din = '0;
    rd_start = 1'b0; rd_abort = 1'b0; rd_ready = 1'b0;
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wt_ce = 1'b1; wt_en = 1'b1; wt_addr = a;
    non_bus_din = d[DW-1:BB]; bus_din = d[BB-1:0];
    @(negedge trig_clk);
  endtask

  task automatic end_capture();
    wt_ce = 1'b0; wt_en = 1'b0; wt_addr = '0;
    non_bus_din = '0; bus_din = '0;
    @(negedge trig_clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cap_done"}, cap_done, 0);
    check({tag, "_cap_count"}, cap_count, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
  endtask

  // Start readout and drain n words against exp_q.
  task automatic read_all(input bit random_ready, input int n);
    int hs = 0;
    int cyc = 1;
    int first = -1;
    bit stalled = 1'b0;
    logic [DW-1:0] hold_d = '0;
    logic hold_l = 1'b0;
    logic [DW-1:0] e;
    rd_start = 1'b1;
    @(negedge trig_clk);
    rd_start = 1'b0;
    while (hs < n && cyc < 300) begin
      if (stalled) begin
        check("stall_valid", rd_valid, 1);
        check("stall_data", rd_data, hold_d);
        check("stall_last", rd_last, hold_l);
      end
      if (rd_valid && first < 0) first = cyc;
      rd_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rd_valid && rd_ready) begin
        e = exp_q.pop_front();
        hs++;
        check("rd_data", rd_data, e);
        check("rd_last", rd_last, (exp_q.size() == 0) ? 1 : 0);
        stalled = 1'b0;
      end else if (rd_valid) begin
        stalled = 1'b1;
        hold_d = rd_data;
        hold_l = rd_last;
      end
      @(negedge trig_clk);
      cyc++;
    end
    rd_ready = 1'b0;
    check("rd_handshakes", hs, n);
    check("rd_first_latency_ok", (first >= 1 && first <= 2) ? 1 : 0, 1);
    exp_q.delete();
    check_idle("after_read");
  endtask

  initial begin
    logic [DW-1:0] d;

    // reset
    clear_inputs();
    jrstn = 1'b0;
    repeat (3) @(negedge trig_clk);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_cap_done", cap_done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_cap_count", cap_count, 0);
    check("rst_rd_data", rd_data, 0);
    jrstn = 1'b1;
    @(negedge trig_clk);

    // reset while a readout is stalled mid-stream
    for (int i = 0; i < 4; i++) write_word(AW'(i), DW'(32'h20 + i));
    end_capture();
    write_word(AW'(1), '1);
    end_capture();
    check("pre_rst_overrun", overrun, 1);
    rd_start = 1'b1;
    @(negedge trig_clk);
    rd_start = 1'b0;
    @(negedge trig_clk);
    check("pre_rst_valid", rd_valid, 1);
    check("pre_rst_data", rd_data, 50'h20);
    jrstn = 1'b0;
    #1;
    check("midrd_rst_rd_valid", rd_valid, 0);
    check("midrd_rst_rd_last", rd_last, 0);
    check("midrd_rst_cap_done", cap_done, 0);
    check("midrd_rst_overrun", overrun, 0);
    check("midrd_rst_cap_count", cap_count, 0);
    check("midrd_rst_rd_data", rd_data, 0);
    @(negedge trig_clk);
    jrstn = 1'b1;
    @(negedge trig_clk);

    // basic 5-word capture and readout
    for (int i = 0; i < 5; i++) begin
      d = {2'(i), 48'(32'h10 + i)};
      write_word(AW'(i), d);
      exp_q.push_back(d);
    end
    end_capture();
    check("basic_cap_done", cap_done, 1);
    check("basic_cap_count", cap_count, 5);
    check("basic_overrun", overrun, 0);
    check("basic_rd_valid_idle", rd_valid, 0);
    read_all(1'b0, 5);

    // readout with pseudo-random back-pressure
    for (int i = 0; i < 5; i++) begin
      d = {2'(3 - (i % 4)), 48'(48'h0000_5A5A_0000 + 48'(i))};
      write_word(AW'(i), d);
      exp_q.push_back(d);
    end
    end_capture();
    check("rand_cap_count", cap_count, 5);
    read_all(1'b1, 5);

    // write attempt while DONE sets overrun and leaves RAM untouched
    for (int i = 0; i < 3; i++) begin
      d = DW'(32'hA0 + i);
      write_word(AW'(i), d);
      exp_q.push_back(d);
    end
    end_capture();
    write_word(AW'(1), '1);
    end_capture();
    check("ovr_overrun", overrun, 1);
    check("ovr_cap_done", cap_done, 1);
    check("ovr_cap_count", cap_count, 3);
    read_all(1'b0, 3);
    check("ovr_sticky", overrun, 1);

    // abort in DONE (with a simultaneous rd_start) clears everything
    write_word(AW'(7), DW'(32'h77));
    write_word(AW'(8), DW'(32'h88));
    end_capture();
    check("abort_pre_cap_done", cap_done, 1);
    check("abort_pre_cap_count", cap_count, 2);
    rd_abort = 1'b1;
    rd_start = 1'b1;
    @(negedge trig_clk);
    rd_abort = 1'b0;
    rd_start = 1'b0;
    check("abort_overrun", overrun, 0);
    check_idle("abort");
    repeat (3) @(negedge trig_clk);
    check("abort_no_stream", rd_valid, 0);

    // capture window without write strobes
    for (int i = 0; i < 3; i++) begin
      wt_ce = 1'b1; wt_en = 1'b0; wt_addr = AW'(i);
      bus_din = 48'(32'hDEAD + i); non_bus_din = 2'(i);
      @(negedge trig_clk);
    end
    end_capture();
    for (int i = 0; i < 3; i++) begin
      check("noen_cap_done", cap_done, 0);
      check("noen_cap_count", cap_count, 0);
      @(negedge trig_clk);
    end
    rd_start = 1'b1;
    @(negedge trig_clk);
    rd_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("noen_rd_valid", rd_valid, 0);
      @(negedge trig_clk);
    end

    // wrap-around: 20 writes into a 16-word ring
    for (int i = 0; i < 20; i++) begin
      write_word(AW'(i), DW'(i));
      if (i >= 4) exp_q.push_back(DW'(i));
    end
    end_capture();
    check("wrap_cap_count", cap_count, 16);
    check("wrap_cap_done", cap_done, 1);
    read_all(1'b0, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cwc_trace_buf.md
Name: cwc_trace_buf

Overview:
- Trace capture buffer directly downstream of the ChipWatcher top (cwc_top).
- Consumes its write strobe and address (wt_ce/wt_en/wt_addr) and stores the probed {non_bus_din, bus_din} samples into an internal RAM.
- After capture ends, streams the stored samples out oldest-first over a valid/ready interface to the readout/JTAG shifter stage.
- Single clock domain (trig_clk); CDC to jtck is handled elsewhere.

Parameters:
- NON_BUS_NODE_NUM, 2: width of non_bus_din.
- BUS_NODE_NUM, 48: width of bus_din.
- DATA_WIDTH, NON_BUS_NODE_NUM+BUS_NODE_NUM: stored word width (derived).
- ADDR_WIDTH, 16: width of wt_addr.
- DEPTH_LOG2, 10: RAM depth is 2**DEPTH_LOG2 words. Must be ≤ ADDR_WIDTH.

Ports:
- trig_clk, in, 1: capture/readout clock.
- jrstn, in, 1: asynchronous active-low reset.
- wt_ce, in, 1: capture window active (from cwc_top).
- wt_en, in, 1: write strobe for this cycle.
- wt_addr, in, ADDR_WIDTH: write address. Only the low DEPTH_LOG2 bits are used.
- non_bus_din, in, NON_BUS_NODE_NUM: probed single-bit nodes. Stored in the upper bits of each word.
- bus_din, in, BUS_NODE_NUM: probed bus nodes. Stored in the lower bits of each word.
- rd_start, in, 1: single-cycle pulse that starts readout.
- rd_abort, in, 1: synchronous abort/clear.
- rd_valid, out, 1: rd_data is valid.
- rd_ready, in, 1: consumer accepts rd_data.
- rd_data, out, DATA_WIDTH: stored sample.
- rd_last, out, 1: qualifies the final word of a readout.
- cap_done, out, 1: capture complete and data ready to read.
- cap_count, out, DEPTH_LOG2+1: number of valid stored words, saturating at 2**DEPTH_LOG2.
- overrun, out, 1: sticky flag; a write was attempted while in DONE or READ.

Behaviour:
- Reset (jrstn=0, async): state=IDLE. rd_valid, rd_last, cap_done, overrun = 0. cap_count=0. rd_data=0. RAM contents are not reset.

States: IDLE, CAPTURE, DONE, READ.
- IDLE → CAPTURE: wt_ce=1. The write in that same cycle is honoured.
- CAPTURE → DONE: first cycle with wt_ce=0, provided cap_count>0. If cap_count=0, go to IDLE instead.
- DONE → READ: rd_start=1.
- READ → IDLE: handshake (rd_valid & rd_ready) completes on a word with rd_last=1. cap_count is cleared and cap_done falls the following cycle.
- Any state → IDLE: rd_abort=1. Takes priority over all other events. Clears cap_count, cap_done, rd_valid and overrun.

Capture writes:
- In IDLE/CAPTURE, wt_ce & wt_en writes the concatenation {non_bus_din, bus_din} to mem[wt_addr[DEPTH_LOG2-1:0]]. Inputs are sampled on the same edge; the RAM write may be pipelined one stage.
- Each write increments cap_count, saturating at 2**DEPTH_LOG2.
- The address of each write is recorded as last_addr.
- Writes with wt_en=0 are ignored.
- wt_ce & wt_en in DONE or READ: no RAM write, overrun=1 (sticky).

Readout:
- Start address: 0 if cap_count < 2**DEPTH_LOG2; otherwise (last_addr+1) mod 2**DEPTH_LOG2, i.e. wrap-around / oldest first.
- Emits exactly cap_count words with incrementing addresses that wrap modulo depth.
- rd_valid first rises no later than 2 cycles after rd_start.
- Standard valid/ready: while rd_valid & !rd_ready, rd_data and rd_last stay stable.
- With rd_ready held high, the stream sustains 1 word/cycle after the first word. Use a 2-entry prefetch/skid buffer to absorb the 1-cycle RAM read latency.
- cap_done is 1 in DONE and READ, and 0 otherwise.

Ignored inputs:
- rd_start in any state except DONE.
- rd_start while rd_abort=1.

Decomposition:
- Package cwc_trace_pkg:
  - state enum (IDLE/CAPTURE/DONE/READ);
  - DEPTH_LOG2 default;
  - function computing the start address from cap_count and last_addr.
- One sub-module: cwc_trace_ram, a simple dual-port RAM (1 write port, 1 registered read port, 1-cycle read latency) so it maps to EBR.
- FSM, counters and skid buffer live in cwc_trace_buf.

Test Plan:
- Reset mid-READ → all outputs 0 immediately. A new capture and readout afterwards works.
- Write 5 samples at wt_addr 0..4 with bus_din=0x10+i, non_bus_din=i; drop wt_ce; pulse rd_start with rd_ready=1 → cap_done=1, cap_count=5, 5 words in order, rd_last on word 4, then IDLE with cap_count=0.
- DEPTH_LOG2=4: write 20 samples at addr 0..19 (values 0..19) → cap_count=16; readout starts at data 4 and ends at 19 (wrap-around order).
- rd_ready toggling pseudo-randomly during readout → no word lost or duplicated; rd_data stable while stalled; total 5 handshakes.
- wt_ce & wt_en asserted during DONE → RAM unchanged on readout, overrun=1. rd_abort → IDLE, overrun=0, cap_count=0.
- wt_ce pulses for 3 cycles with wt_en=0 → returns to IDLE, cap_done never asserts. A subsequent rd_start is ignored (rd_valid stays 0).
